// File: rtl/fetch_decode_buffer_pkg.sv
// Shared IF/ID constants: instruction/PC widths and the decode-side NOP encoding.
package fetch_decode_buffer_pkg;

  localparam int unsigned IF_INS_W = 32;
  localparam int unsigned IF_PC_W  = 10;

  // All-zero word decodes as sll $0,$0,0, a harmless bubble for decode
  localparam logic [IF_INS_W-1:0] IF_NOP = 32'h0;

endpackage

// File: rtl/ifid_fifo_mem.sv
// Storage array for the IF/ID buffer: DEPTH x W registers, one synchronous
// write port and one asynchronous read port. The array is deliberately not reset;
// validity is tracked by the controller's count.
//  clk    in  rising-edge clock
//  we     in  write enable
//  waddr  in  write index
//  wdata  in  write payload
//  raddr  in  read index
//  rdata  out read payload (combinational)
module ifid_fifo_mem #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 42,
  parameter int unsigned AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Async read port
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID boundary. Buffers {instruction, PC+4} from fetch in a small FIFO
// and offers the oldest entry to decode with valid/ready. Fetch sees a registered
// ready; a taken branch/jump (flush) discards everything held and is tallied in a
// saturating drop counter.
//  clk, reset_n          clock, async active-low reset
//  in_valid/in_ins/in_pc4  fetch payload;  in_ready  registered accept
//  flush                 taken branch/jump from downstream
//  out_valid/out_ins/out_pc4  head entry to decode;  out_ready  decode accept
//  occupancy             held entry count
//  flush_drops           saturating count of entries discarded by flush
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = IF_INS_W,
  parameter int unsigned PC_W   = IF_PC_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STAT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_ins,
  input  logic [PC_W-1:0]            in_pc4,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_ins,
  output logic [PC_W-1:0]            out_pc4,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [STAT_W-1:0]          flush_drops
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_W + PC_W;
  localparam int unsigned SW = STAT_W + 2;
  localparam logic [STAT_W-1:0] DROP_MAX = '1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              init_done_q;
  logic              in_ready_q, in_ready_d;
  logic [STAT_W-1:0] drops_q, drops_d;

  logic              push_attempt;
  logic              push;
  logic              pop;
  logic [SW-1:0]     drop_sum;
  logic [EW-1:0]     head_data;

  ifid_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_ins, in_pc4}),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  // Head presentation; flush hides the head in its own cycle so no pop can occur
  always_comb begin
    out_valid = (count_q != '0) && !flush;
    out_ins   = DATA_W'(IF_NOP);
    out_pc4   = '0;
    if (out_valid) begin
      out_ins = head_data[EW-1:PC_W];
      out_pc4 = head_data[PC_W-1:0];
    end
  end

  // Handshake qualification; in_ready_q already excludes the full case
  always_comb begin
    push_attempt = in_valid && in_ready_q;
    push         = push_attempt && !flush;
    pop          = out_valid && out_ready;
  end

  // Next-state for pointers, count, ready and drop statistic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    drop_sum = SW'(drops_q) + SW'(count_q) + SW'(push_attempt);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drops_d  = (drop_sum > SW'(DROP_MAX)) ? DROP_MAX : STAT_W'(drop_sum);
    end else begin
      if (push) begin
        wr_ptr_d = AW'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      end
      unique case ({push, pop})
        2'b10:   count_d = CW'(count_q + 1'b1);
        2'b01:   count_d = CW'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end

    // Uses the current init flag so ready rises one cycle after init completes
    in_ready_d = init_done_q && (count_d != CW'(DEPTH));
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      init_done_q <= 1'b0;
      in_ready_q  <= 1'b0;
      drops_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      init_done_q <= 1'b1;
      in_ready_q  <= in_ready_d;
      drops_q     <= drops_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign occupancy   = count_q;
  assign flush_drops = drops_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer with hand-computed expectations.
module tb_fetch_decode_buffer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [9:0]  in_pc4;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [9:0]  out_pc4;
  logic        out_ready;
  logic [1:0]  occupancy;
  logic [7:0]  flush_drops;

  int total;
  int bad;

  fetch_decode_buffer #(
    .DATA_W (32),
    .PC_W   (10),
    .DEPTH  (2),
    .STAT_W (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ins      (in_ins),
    .in_pc4      (in_pc4),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ins     (out_ins),
    .out_pc4     (out_pc4),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .flush_drops (flush_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [9:0] pc4);
    in_valid = v;
    in_ins   = ins;
    in_pc4   = pc4;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 10'h0);

    // 1: reset then idle
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ins", 64'(out_ins), 64'h0);
    chk("rst_out_pc4", 64'(out_pc4), 64'h0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_drops", 64'(flush_drops), 64'd0);
    #10 reset_n = 1'b1;
    tick();
    chk("init_edge1_ready", 64'(in_ready), 64'd0);
    tick();
    chk("init_edge2_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_ins", 64'(out_ins), 64'h0);

    // 2: streaming with decode always ready
    out_ready = 1'b1;
    drive(1'b1, 32'h20080005, 10'd4);
    tick();
    drive(1'b1, 32'h200A0003, 10'd8);
    #1;
    chk("str1_valid", 64'(out_valid), 64'd1);
    chk("str1_ins", 64'(out_ins), 64'h20080005);
    chk("str1_pc4", 64'(out_pc4), 64'd4);
    chk("str1_occ", 64'(occupancy), 64'd1);
    tick();
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("str2_ins", 64'(out_ins), 64'h200A0003);
    chk("str2_pc4", 64'(out_pc4), 64'd8);
    chk("str2_occ", 64'(occupancy), 64'd1);
    chk("str2_ready", 64'(in_ready), 64'd1);
    tick();
    chk("str_empty_valid", 64'(out_valid), 64'd0);
    chk("str_empty_ins", 64'(out_ins), 64'h0);
    chk("str_empty_occ", 64'(occupancy), 64'd0);

    // 3: stall fill, third word held by fetch, then drain
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 10'd12);
    tick();
    chk("fill1_occ", 64'(occupancy), 64'd1);
    chk("fill1_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h22222222, 10'd16);
    tick();
    chk("fill2_occ", 64'(occupancy), 64'd2);
    chk("fill2_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h33333333, 10'd20);
    tick();
    chk("full_hold_occ", 64'(occupancy), 64'd2);
    chk("full_hold_ins", 64'(out_ins), 64'h11111111);
    out_ready = 1'b1;
    #1;
    chk("drain_a_ins", 64'(out_ins), 64'h11111111);
    chk("drain_a_pc4", 64'(out_pc4), 64'd12);
    tick();
    chk("drain_b_ins", 64'(out_ins), 64'h22222222);
    chk("drain_b_pc4", 64'(out_pc4), 64'd16);
    chk("drain_b_ready", 64'(in_ready), 64'd1);
    chk("drain_b_occ", 64'(occupancy), 64'd1);
    tick();
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("drain_c_ins", 64'(out_ins), 64'h33333333);
    chk("drain_c_pc4", 64'(out_pc4), 64'd20);
    chk("drain_c_occ", 64'(occupancy), 64'd1);
    tick();
    chk("drain_done_valid", 64'(out_valid), 64'd0);
    chk("drain_done_occ", 64'(occupancy), 64'd0);

    // 4: flush while full with a refused push pending
    out_ready = 1'b0;
    drive(1'b1, 32'h44444444, 10'd24);
    tick();
    drive(1'b1, 32'h55555555, 10'd28);
    tick();
    drive(1'b1, 32'h66666666, 10'd32);
    chk("pf_occ", 64'(occupancy), 64'd2);
    chk("pf_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    #1;
    chk("flushfull_valid", 64'(out_valid), 64'd0);
    chk("flushfull_ins", 64'(out_ins), 64'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("flushfull_occ", 64'(occupancy), 64'd0);
    chk("flushfull_drops", 64'(flush_drops), 64'd2);
    chk("flushfull_ready", 64'(in_ready), 64'd1);

    // 5: flush with one held entry and a push attempt in the same cycle
    drive(1'b1, 32'h77777777, 10'd36);
    tick();
    drive(1'b1, 32'h88888888, 10'd40);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("flushpush_occ", 64'(occupancy), 64'd0);
    chk("flushpush_valid", 64'(out_valid), 64'd0);
    chk("flushpush_drops", 64'(flush_drops), 64'd4);

    // Walk the counter up to 254 in steps of 2
    for (int k = 0; k < 125; k++) begin
      drive(1'b1, 32'hA0000000 + 32'(k), 10'd44);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("sat_pre_drops", 64'(flush_drops), 64'd254);
    drive(1'b1, 32'hBBBBBBBB, 10'd48);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("sat_drops", 64'(flush_drops), 64'd255);
    drive(1'b1, 32'hCCCCCCCC, 10'd52);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("sat_hold_drops", 64'(flush_drops), 64'd255);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("empty_flush_drops", 64'(flush_drops), 64'd255);
    chk("empty_flush_occ", 64'(occupancy), 64'd0);

    // 6: async reset mid-stream with two held entries
    out_ready = 1'b0;
    drive(1'b1, 32'h99999999, 10'd56);
    tick();
    drive(1'b1, 32'hDDDDDDDD, 10'd60);
    tick();
    drive(1'b0, 32'h0, 10'd0);
    #1;
    chk("prerst_occ", 64'(occupancy), 64'd2);
    chk("prerst_ins", 64'(out_ins), 64'h99999999);
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 64'(in_ready), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ins", 64'(out_ins), 64'h0);
    chk("arst_pc4", 64'(out_pc4), 64'h0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_drops", 64'(flush_drops), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rel_edge1_ready", 64'(in_ready), 64'd0);
    tick();
    chk("rel_edge2_ready", 64'(in_ready), 64'd1);
    chk("rel_valid", 64'(out_valid), 64'd0);
    chk("rel_ins", 64'(out_ins), 64'h0);
    chk("rel_occ", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
